// File: rtl/calc_entry_pkg.sv
// Shared types and constants for the calculator operand-entry datapath.
package calc_entry_pkg;

    localparam int BCD_W              = 10;
    localparam int MAX_TENS_FOR_SHIFT = 3;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic             neg;
        logic [BCD_W-1:0] val;
    } bcd_operand_t;

endpackage

// File: rtl/key_debounce.sv
// Per-button 2-FF synchronizer, debounce counter and one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            vld_q    <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    // Arming waits until the synchronizer holds real samples showing the button
    // released, so a button held across reset never yields a press.
    always_comb begin
        sync_d   = {sync_q[0], btn_n};
        vld_d    = {vld_q[0], 1'b1};
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        armed_d  = armed_q | (vld_q[1] & sync_q[1]);
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1] & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// Debounced button handling and FSM that builds two signed 3-digit BCD operands.
// Optional macro ENTRY_BACKSPACE_EN turns the clear button into a backspace.
module bcd_operand_entry
    import calc_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sw_digit,
    input  logic             btn_digit_n,
    input  logic             btn_sign_n,
    input  logic             btn_clear_n,
    input  logic             btn_enter_n,
    output logic [BCD_W-1:0] A,
    output logic             negativeA,
    output logic [BCD_W-1:0] B,
    output logic             negativeB,
    output logic             key,
    output logic             calc_start,
    output logic             entry_err
);

    logic [3:0] btn_raw_n;
    logic [3:0] press;

    assign btn_raw_n = {btn_enter_n, btn_clear_n, btn_sign_n, btn_digit_n};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .btn_n(btn_raw_n[i]),
            .press(press[i])
        );
    end

    entry_state_e state_q, state_d;
    bcd_operand_t a_q, a_d, b_q, b_d;
    logic         calc_start_q, calc_start_d;
    logic         entry_err_q, entry_err_d;
    bcd_operand_t cur, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_A;
            a_q          <= '0;
            b_q          <= '0;
            calc_start_q <= 1'b0;
            entry_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            calc_start_q <= calc_start_d;
            entry_err_q  <= entry_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        calc_start_d = 1'b0;
        entry_err_d  = 1'b0;
        cur          = (state_q == S_B) ? b_q : a_q;
        nxt          = cur;
        case (state_q)
            S_A, S_B: begin
                if (press[3]) begin
                    state_d      = (state_q == S_A) ? S_B : S_RES;
                    calc_start_d = (state_q == S_B);
                end else if (press[2]) begin
`ifdef ENTRY_BACKSPACE_EN
                    nxt.val = {4'b0000, cur.val[9:8], cur.val[7:4]};
                    if (nxt.val == '0) nxt.neg = 1'b0;
`else
                    nxt = '0;
`endif
                end else if (press[1]) begin
                    if (cur.val != '0) nxt.neg = ~cur.neg;
                end else if (press[0]) begin
                    if (sw_digit > 4'd9 || cur.val[7:4] > 4'(MAX_TENS_FOR_SHIFT)) begin
                        entry_err_d = 1'b1;
                    end else begin
                        // The hundreds digit falls off; a zero result drops the sign.
                        nxt.val = {cur.val[5:0], sw_digit};
                        if (nxt.val == '0) nxt.neg = 1'b0;
                    end
                end
                if (state_q == S_A) a_d = nxt;
                else                b_d = nxt;
            end
            S_RES: begin
                if (press[3]) begin
                    state_d = S_A;
                    a_d     = '0;
                    b_d     = '0;
                end
            end
            default: state_d = S_A;
        endcase
    end

    assign A          = a_q.val;
    assign negativeA  = a_q.neg;
    assign B          = b_q.val;
    assign negativeB  = b_q.neg;
    assign key        = (state_q == S_RES);
    assign calc_start = calc_start_q;
    assign entry_err  = entry_err_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Randomized and directed bench for bcd_operand_entry with a behavioural model.
module tb_bcd_operand_entry;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_digit = 4'd0;
    logic [3:0] raw_n = 4'hF;   // [0]=digit [1]=sign [2]=clear [3]=enter
    logic [9:0] A, B;
    logic       negativeA, negativeB, key, calc_start, entry_err;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int cs_cnt  = 0;

    bcd_operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_digit   (sw_digit),
        .btn_digit_n(raw_n[0]),
        .btn_sign_n (raw_n[1]),
        .btn_clear_n(raw_n[2]),
        .btn_enter_n(raw_n[3]),
        .A          (A),
        .negativeA  (negativeA),
        .B          (B),
        .negativeB  (negativeB),
        .key        (key),
        .calc_start (calc_start),
        .entry_err  (entry_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_st;          // 0: editing A, 1: editing B, 2: showing result
    int m_val[2];
    bit m_neg[2];
    bit m_cs, m_err;
    bit m_p[4];
    bit m_d1[4], m_d2[4], m_acc[4], m_armed[4], m_runv[4];
    int m_run[4];
    int m_age;

    function automatic logic [9:0] to_bcd(input int v);
        logic [9:0] r;
        r = {2'((v / 100) % 4), 4'((v / 10) % 10), 4'(v % 10)};
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_val[0] = 0; m_val[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
            m_cs = 0; m_err = 0; m_age = 0;
            for (int b = 0; b < 4; b++) begin
                m_p[b] = 0; m_d1[b] = 1; m_d2[b] = 1; m_acc[b] = 1;
                m_armed[b] = 0; m_runv[b] = 1; m_run[b] = 0;
            end
        end else begin
            bit np[4];
            bit seen;
            int x;
            m_cs = 0; m_err = 0;
            if (m_p[3]) begin
                if (m_st == 0) m_st = 1;
                else if (m_st == 1) begin m_st = 2; m_cs = 1; end
                else begin
                    m_st = 0; m_val[0] = 0; m_val[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
                end
            end else if (m_st != 2) begin
                x = m_st;
                if (m_p[2]) begin
`ifdef ENTRY_BACKSPACE_EN
                    m_val[x] = m_val[x] / 10;
`else
                    m_val[x] = 0;
`endif
                    if (m_val[x] == 0) m_neg[x] = 0;
                end else if (m_p[1]) begin
                    if (m_val[x] != 0) m_neg[x] = !m_neg[x];
                end else if (m_p[0]) begin
                    if (int'(sw_digit) > 9 || (m_val[x] / 10) % 10 > 3) m_err = 1;
                    else begin
                        m_val[x] = (m_val[x] % 100) * 10 + int'(sw_digit);
                        if (m_val[x] == 0) m_neg[x] = 0;
                    end
                end
            end
            // button level seen two cycles late; accepted after D equal samples
            for (int b = 0; b < 4; b++) begin
                seen = (m_age >= 2) ? m_d2[b] : 1'b1;
                if (seen == m_runv[b]) m_run[b] = (m_run[b] < 1000) ? m_run[b] + 1 : m_run[b];
                else begin m_runv[b] = seen; m_run[b] = 1; end
                np[b] = 0;
                if (m_runv[b] != m_acc[b] && m_run[b] >= D) begin
                    m_acc[b] = m_runv[b];
                    np[b] = (m_runv[b] == 0) && m_armed[b];
                end
                if (m_age >= 2 && seen) m_armed[b] = 1;
                m_d2[b] = m_d1[b];
                m_d1[b] = raw_n[b];
            end
            if (m_age < 1000) m_age++;
            for (int b = 0; b < 4; b++) m_p[b] = np[b];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("A",          32'(A),          32'(to_bcd(m_val[0])));
        check("negativeA",  32'(negativeA),  32'(m_neg[0]));
        check("B",          32'(B),          32'(to_bcd(m_val[1])));
        check("negativeB",  32'(negativeB),  32'(m_neg[1]));
        check("key",        32'(key),        32'(m_st == 2));
        check("calc_start", 32'(calc_start), 32'(m_cs));
        check("entry_err",  32'(entry_err),  32'(m_err));
        if (entry_err)  err_cnt++;
        if (calc_start) cs_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        raw_n = ~mask;
        step(hold);
        raw_n = 4'hF;
        step(10);
    endtask

    task automatic digit(input logic [3:0] d);
        sw_digit = d;
        press(4'b0001, 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, c0;
        step(3);
        check("reset_A",   32'(A), 32'h0);
        check("reset_key", 32'(key), 32'h0);
        rst_n = 1'b1;
        step(5);

        press(4'b0010, 6);
        check("sign_on_zero", 32'(negativeA), 32'h0);
        digit(4'd5);
        check("A_5", 32'(A), 32'h005);
        press(4'b0010, 6);
        check("sign_on_5", 32'(negativeA), 32'h1);
        press(4'b0100, 6);
        check("clear_A", 32'(A), 32'h0);
        check("clear_negA", 32'(negativeA), 32'h0);

        // latency: raw edge to visible register update is 2+D+1 cycles
        sw_digit = 4'd1;
        raw_n = 4'b1110;
        step(6);
        check("lat_before", 32'(A), 32'h000);
        step(1);
        check("lat_after", 32'(A), 32'h001);
        raw_n = 4'hF;
        step(10);
        digit(4'd2);
        digit(4'd3);
        check("A_123", 32'(A), 32'(10'b01_0010_0011));
        press(4'b0100, 6);
`ifdef ENTRY_BACKSPACE_EN
        check("backspace", 32'(A), 32'h012);
`else
        check("clear_123", 32'(A), 32'h000);
`endif

        press(4'b1000, 6);
        check("S_B_key", 32'(key), 32'h0);
        check("S_B_B0", 32'(B), 32'h0);
        sw_digit = 4'd5;
        press(4'b0001, 3);
        check("glitch", 32'(B), 32'h0);
        digit(4'd4);
        digit(4'd2);
        check("B_42", 32'(B), 32'h042);
        e0 = err_cnt;
        digit(4'd7);
        check("ovf_err", 32'(err_cnt), 32'(e0 + 1));
        check("ovf_keep", 32'(B), 32'h042);
        digit(4'hC);
        check("bad_digit_err", 32'(err_cnt), 32'(e0 + 2));
        check("bad_digit_keep", 32'(B), 32'h042);

        c0 = cs_cnt;
        press(4'b1000, 6);
        check("res_key", 32'(key), 32'h1);
        check("calc_start_once", 32'(cs_cnt), 32'(c0 + 1));
        press(4'b1000, 6);
        check("back_key", 32'(key), 32'h0);
        check("back_A0", 32'(A), 32'h0);
        check("back_B0", 32'(B), 32'h0);

        sw_digit = 4'd3;
        press(4'b1001, 6);
        check("simul_A", 32'(A), 32'h0);
        digit(4'd8);
        check("simul_state", 32'(B), 32'h008);
        check("simul_A2", 32'(A), 32'h0);

        for (int n = 0; n < 250; n++) begin
            logic [3:0] m;
            int r;
            r = int'($urandom_range(0, 9));
            m = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0 && m[3]) m[3] = 1'b0;
            sw_digit = 4'($urandom_range(0, 15));
            press(m, int'($urandom_range(1, 8)));
        end

        // held through reset must not count until re-pressed
        sw_digit = 4'd6;
        raw_n = 4'b1110;
        step(2);
        rst_n = 1'b0;
        step(3);
        check("rst_mid_A", 32'(A), 32'h0);
        rst_n = 1'b1;
        step(20);
        check("held_no_press", 32'(A), 32'h0);
        raw_n = 4'hF;
        step(10);
        check("held_release", 32'(A), 32'h0);
        digit(4'd6);
        check("repress", 32'(A), 32'h006);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
